// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/JAL/JALR resolution with redirect handshake and flush.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module branch_resolve_unit #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [2:0]      funct3,
   input  logic            beq,
   input  logic            bne,
   input  logic            blt,
   input  logic            bge,
   input  logic            bltu,
   input  logic            bgeu,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic            res_valid,
   output logic            taken,
   output logic [XLEN-1:0] link,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            misalign_exc,
`ifdef BRANCH_STATS_EN
   input  logic            stat_clr,
   output logic [31:0]     stat_taken,
   output logic [31:0]     stat_not_taken,
`endif
   output logic            illegal_br
);

   typedef enum logic [1:0] {
      IDLE,
      REDIRECT,
      FLUSH
   } state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic            accept;
   logic            cond;
   logic            illegal;
   logic            is_taken;
   logic            misal;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] link_nx;

   assign in_ready = rst_n && (state == IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = beq;
         3'b001:  cond = bne;
         3'b100:  cond = blt;
         3'b101:  cond = bge;
         3'b110:  cond = bltu;
         3'b111:  cond = bgeu;
         default: cond = 1'b0;
      endcase
   end

   assign illegal = is_branch && (funct3[2:1] == 2'b01);

   always_comb begin
      sum    = is_jalr ? (rs1 + imm) : (pc + imm);
      target = sum;
      if (is_jalr)
         target[0] = 1'b0;
   end

   assign is_taken = is_jal || is_jalr || (is_branch && cond);
   assign misal    = is_taken && target[1];
   assign link_nx  = (is_jal || is_jalr) ? (pc + XLEN'(4)) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         res_valid      <= 1'b0;
         taken          <= 1'b0;
         link           <= '0;
         misalign_exc   <= 1'b0;
         illegal_br     <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
      end else begin
         res_valid    <= accept;
         taken        <= accept && is_taken;
         link         <= accept ? link_nx : '0;
         misalign_exc <= accept && misal;
         illegal_br   <= accept && illegal;
         case (state)
            IDLE: begin
               if (accept && is_taken && !misal) begin
                  state          <= REDIRECT;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target;
               end
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  state          <= FLUSH;
                  redirect_valid <= 1'b0;
                  flush          <= 1'b1;
                  cnt            <= 4'(FLUSH_CYCLES);
               end
            end
            FLUSH: begin
               // counter value 1 marks the last flush cycle
               if (cnt <= 4'd1) begin
                  state <= IDLE;
                  flush <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               flush          <= 1'b0;
               cnt            <= '0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_taken     <= '0;
         stat_not_taken <= '0;
      end else if (stat_clr) begin
         stat_taken     <= '0;
         stat_not_taken <= '0;
      end else if (accept && is_branch) begin
         if (is_taken) begin
            if (stat_taken != 32'hFFFF_FFFF)
               stat_taken <= stat_taken + 32'd1;
         end else begin
            if (stat_not_taken != 32'hFFFF_FFFF)
               stat_not_taken <= stat_not_taken + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus
// randomized ops compared every cycle against a transaction-level model.
module tb_branch_resolve_unit;

   localparam int XLEN = 32;
   localparam int FC   = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            is_branch = 1'b0;
   logic            is_jal = 1'b0;
   logic            is_jalr = 1'b0;
   logic [2:0]      funct3 = '0;
   logic            beq = 1'b0;
   logic            bne = 1'b0;
   logic            blt = 1'b0;
   logic            bge = 1'b0;
   logic            bltu = 1'b0;
   logic            bgeu = 1'b0;
   logic [XLEN-1:0] pc = '0;
   logic [XLEN-1:0] imm = '0;
   logic [XLEN-1:0] rs1 = '0;
   logic            res_valid;
   logic            taken;
   logic [XLEN-1:0] link;
   logic            redirect_valid;
   logic            redirect_ready = 1'b0;
   logic [XLEN-1:0] redirect_pc;
   logic            flush;
   logic            misalign_exc;
   logic            illegal_br;
`ifdef BRANCH_STATS_EN
   logic            stat_clr = 1'b0;
   logic [31:0]     stat_taken;
   logic [31:0]     stat_not_taken;
`endif

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .is_branch(is_branch),
      .is_jal(is_jal),
      .is_jalr(is_jalr),
      .funct3(funct3),
      .beq(beq),
      .bne(bne),
      .blt(blt),
      .bge(bge),
      .bltu(bltu),
      .bgeu(bgeu),
      .pc(pc),
      .imm(imm),
      .rs1(rs1),
      .res_valid(res_valid),
      .taken(taken),
      .link(link),
      .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc),
      .flush(flush),
      .misalign_exc(misalign_exc),
`ifdef BRANCH_STATS_EN
      .stat_clr(stat_clr),
      .stat_taken(stat_taken),
      .stat_not_taken(stat_not_taken),
`endif
      .illegal_br(illegal_br)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // transaction-level model: what the unit owes after each edge
   bit          e_res, e_taken, e_mis, e_ill;
   logic [31:0] e_link;
   bit          m_redir;
   logic [31:0] m_rpc;
   int          m_flush_left;

   function automatic bit cond_of(input logic [2:0] f);
      case (f)
         3'b000:  return beq;
         3'b001:  return bne;
         3'b100:  return blt;
         3'b101:  return bge;
         3'b110:  return bltu;
         3'b111:  return bgeu;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit          rdy, acc, tk, ill, xfer;
      logic [31:0] tgt;
      if (!rst_n) begin
         e_res        <= 0;
         e_taken      <= 0;
         e_mis        <= 0;
         e_ill        <= 0;
         e_link       <= '0;
         m_redir      <= 0;
         m_rpc        <= '0;
         m_flush_left <= 0;
      end else begin
         rdy  = !m_redir && (m_flush_left == 0);
         acc  = in_valid && rdy;
         xfer = is_jal || is_jalr;
         tgt  = is_jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
         ill  = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
         tk   = xfer || (is_branch && !ill && cond_of(funct3));
         e_res   <= acc;
         e_taken <= acc && tk;
         e_link  <= (acc && xfer) ? pc + 32'd4 : 32'd0;
         e_mis   <= acc && tk && tgt[1];
         e_ill   <= acc && ill;
         if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
         end else if (m_redir) begin
            if (redirect_ready) begin
               m_redir      <= 0;
               m_flush_left <= FC;
            end
         end else if (acc && tk && !tgt[1]) begin
            m_redir <= 1;
            m_rpc   <= tgt;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready),
          32'(rst_n && !m_redir && m_flush_left == 0));
      chk("res_valid", 32'(res_valid), 32'(e_res));
      chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
      chk("illegal_br", 32'(illegal_br), 32'(e_ill));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
      chk("flush", 32'(flush), 32'(m_flush_left > 0));
      if (e_res) begin
         chk("taken", 32'(taken), 32'(e_taken));
         chk("link", link, e_link);
      end
      if (m_redir)
         chk("redirect_pc", redirect_pc, m_rpc);
   end

   task automatic set_op(input int k, input logic [2:0] f,
                         input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] r);
      in_valid  = 1'b1;
      is_branch = (k == 0);
      is_jal    = (k == 1);
      is_jalr   = (k == 2);
      funct3    = f;
      pc        = p;
      imm       = i;
      rs1       = r;
      {beq, bne, blt, bge, bltu, bgeu} = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nres, nfl, nbusy, nrv;
      int k;

      // reset and release
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      chk("flush_after_rst", 32'(flush), 32'd0);

      // BEQ taken, fetch ready in advance
      tick();
      redirect_ready = 1'b1;
      set_op(0, 3'b000, 32'h100, 32'h20, 32'h0);
      beq = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("beq_res", 32'(res_valid), 32'd1);
      chk("beq_taken", 32'(taken), 32'd1);
      chk("beq_rv", 32'(redirect_valid), 32'd1);
      chk("beq_rpc", redirect_pc, 32'h120);
      nfl   = 0;
      nbusy = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nfl   += int'(flush);
         nbusy += int'(!in_ready);
      end
      chk("beq_flush_cycles", 32'(nfl), 32'd2);
      chk("beq_busy_cycles", 32'(nbusy), 32'd3);

      // BLTU not-taken stream
      nres  = 0;
      nbusy = 0;
      nrv   = 0;
      tick();
      for (int i = 0; i < 6; i++) begin
         set_op(0, 3'b110, 32'h400 + 32'(4 * i), 32'h40, 32'h0);
         in_valid = (i < 4);
         @(negedge clk);
         nres  += int'(res_valid && !taken);
         nbusy += int'(!in_ready);
         nrv   += int'(redirect_valid);
         tick();
      end
      in_valid = 1'b0;
      chk("bltu_pulses", 32'(nres), 32'd4);
      chk("bltu_busy", 32'(nbusy), 32'd0);
      chk("bltu_redirects", 32'(nrv), 32'd0);

      // JALR with stalled fetch
      redirect_ready = 1'b0;
      set_op(2, 3'b000, 32'h300, 32'h5, 32'h1003);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("jalr_link", link, 32'h304);
      chk("jalr_taken", 32'(taken), 32'd1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk("jalr_rv_held", 32'(redirect_valid), 32'd1);
         chk("jalr_rpc_held", redirect_pc, 32'h1008);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      chk("jalr_rv_drop", 32'(redirect_valid), 32'd0);
      chk("jalr_flush", 32'(flush), 32'd1);
      repeat (3) tick();

      // misaligned JAL, then illegal branch
      set_op(1, 3'b000, 32'h200, 32'h6, 32'h0);
      tick();
      set_op(0, 3'b010, 32'h500, 32'h8, 32'h0);
      beq = 1'b1;
      @(negedge clk);
      chk("mis_exc", 32'(misalign_exc), 32'd1);
      chk("mis_taken", 32'(taken), 32'd1);
      chk("mis_link", link, 32'h204);
      chk("mis_rv", 32'(redirect_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ill_br", 32'(illegal_br), 32'd1);
      chk("ill_taken", 32'(taken), 32'd0);
      chk("ill_rv", 32'(redirect_valid), 32'd0);

      // reset during the second flush cycle
      tick();
      set_op(0, 3'b001, 32'h600, 32'h10, 32'h0);
      bne = 1'b1;
      tick();
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst_pre_flush", 32'(flush), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_rv", 32'(redirect_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", 32'(in_ready), 32'd1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst_n     = ($urandom_range(0, 499) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         k         = $urandom_range(0, 9);
         is_branch = (k < 5);
         is_jal    = (k == 5 || k == 6);
         is_jalr   = (k == 7 || k == 8);
         funct3    = 3'($urandom);
         {beq, bne, blt, bge, bltu, bgeu} = 6'($urandom);
         pc        = $urandom & 32'hFFFF_FFFC;
         imm       = $urandom & 32'hFFFF_FFFE;
         rs1       = $urandom;
         redirect_ready = ($urandom_range(0, 2) != 0);
      end
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      redirect_ready = 1'b1;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
